// File: rtl/seg7_pattern_engine.sv
// Animated pattern generator for a multiplexed 7-segment display.
// A free-running scan selects one digit at a time; a paused-able step timer advances the pattern.
module seg7_pattern_engine #(
    parameter int NUM_DIGITS = 4,
    parameter int PRESCALE   = 20_000_000,
    parameter int SCAN_DIV   = 50_000
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [1:0]            mode_i,
    input  logic [1:0]            speed_i,
    input  logic                  pause_i,
    output logic [6:0]            seg_o,
    output logic [NUM_DIGITS-1:0] dig_o,
    output logic                  step_o
);

    localparam int CNT_W  = $clog2(PRESCALE + 1);
    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0]      PRESCALE_V = CNT_W'(PRESCALE);
    localparam logic [SCAN_W-1:0]     SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]      DIG_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] DIG0       = NUM_DIGITS'(1);
    localparam logic [6:0]            SEG_A      = 7'h01;
    localparam logic [6:0]            SEG_G      = 7'h40;
    localparam logic [6:0]            SEG_ALL    = 7'h7F;

    typedef enum logic [1:0] {
        MODE_FLASH = 2'd0,
        MODE_SPIN  = 2'd1,
        MODE_CHASE = 2'd2,
        MODE_SNAKE = 2'd3
    } mode_e;

    mode_e                r_mode;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_phase;
    logic [2:0]           r_seg_idx;
    logic [IDX_W-1:0]     r_pos;
    logic [SCAN_W-1:0]    r_scan_cnt;
    logic [IDX_W-1:0]     r_scan_idx;
    logic [6:0]           r_seg;
    logic [NUM_DIGITS-1:0] r_dig;
    logic                 r_step;

    logic [CNT_W-1:0]     w_limit_m1;
    logic                 w_term;
    logic                 w_mode_chg;
    logic                 w_step;
    logic                 w_phase_nxt;
    logic [2:0]           w_seg_idx_nxt;
    logic [IDX_W-1:0]     w_pos_nxt;
    logic [IDX_W-1:0]     w_pos_inc;
    logic [6:0]           w_spin;
    logic                 w_on_pos;
    logic [6:0]           w_seg;

    // ">=" rather than "==" so a speed increase past the current count steps at once.
    assign w_limit_m1 = (PRESCALE_V >> speed_i) - CNT_W'(1);
    assign w_term     = (r_cnt >= w_limit_m1);
    assign w_mode_chg = (mode_e'(mode_i) != r_mode);
    assign w_step     = !w_mode_chg && !pause_i && w_term;
    assign w_pos_inc  = (r_pos == DIG_LAST) ? '0 : r_pos + IDX_W'(1);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_phase_nxt   = r_phase;
        w_seg_idx_nxt = r_seg_idx;
        w_pos_nxt     = r_pos;
        case (r_mode)
            MODE_FLASH: w_phase_nxt = ~r_phase;
            MODE_SPIN:  w_seg_idx_nxt = (r_seg_idx == 3'd5) ? 3'd0 : r_seg_idx + 3'd1;
            MODE_CHASE: w_pos_nxt = w_pos_inc;
            MODE_SNAKE: begin
                w_seg_idx_nxt = (r_seg_idx == 3'd5) ? 3'd0 : r_seg_idx + 3'd1;
                if (r_seg_idx == 3'd5) w_pos_nxt = w_pos_inc;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_mode    <= MODE_FLASH;
            r_cnt     <= '0;
            r_phase   <= 1'b0;
            r_seg_idx <= '0;
            r_pos     <= '0;
            r_step    <= 1'b0;
        end else begin
            r_step <= w_step;
            if (w_mode_chg) begin
                r_mode    <= mode_e'(mode_i);
                r_cnt     <= '0;
                r_phase   <= 1'b0;
                r_seg_idx <= '0;
                r_pos     <= '0;
            end else if (!pause_i) begin
                if (w_term) begin
                    r_cnt     <= '0;
                    r_phase   <= w_phase_nxt;
                    r_seg_idx <= w_seg_idx_nxt;
                    r_pos     <= w_pos_nxt;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_scan_cnt <= '0;
            r_scan_idx <= '0;
        end else if (r_scan_cnt == SCAN_LAST) begin
            r_scan_cnt <= '0;
            r_scan_idx <= (r_scan_idx == DIG_LAST) ? '0 : r_scan_idx + IDX_W'(1);
        end else begin
            r_scan_cnt <= r_scan_cnt + SCAN_W'(1);
        end
    end

    assign w_spin   = SEG_A << r_seg_idx;
    assign w_on_pos = (r_scan_idx == r_pos);

    always_comb begin
        w_seg = '0;
        case (r_mode)
            MODE_FLASH: w_seg = r_phase ? SEG_ALL : 7'h00;
            MODE_SPIN:  w_seg = w_spin;
            MODE_CHASE: w_seg = w_on_pos ? SEG_G : 7'h00;
            MODE_SNAKE: w_seg = w_on_pos ? w_spin : 7'h00;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_seg <= '0;
            r_dig <= DIG0;
        end else begin
            r_seg <= w_seg;
            r_dig <= DIG0 << r_scan_idx;
        end
    end

    assign seg_o  = r_seg;
    assign dig_o  = r_dig;
    assign step_o = r_step;

endmodule

// File: tb/tb_seg7_pattern_engine.sv
// Self-checking bench: arithmetic pattern model compared every cycle, plus literal scenario checks.
module tb_seg7_pattern_engine;

    localparam int N  = 4;
    localparam int PS = 16;
    localparam int SD = 2;

    logic         clk;
    logic         rst_n;
    logic [1:0]   mode;
    logic [1:0]   speed;
    logic         pause;
    logic [6:0]   seg;
    logic [N-1:0] dig;
    logic         step;

    int     n_pass  = 0;
    int     n_total = 0;
    longint cyc     = 0;

    seg7_pattern_engine #(
        .NUM_DIGITS(N),
        .PRESCALE  (PS),
        .SCAN_DIV  (SD)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .mode_i (mode),
        .speed_i(speed),
        .pause_i(pause),
        .seg_o  (seg),
        .dig_o  (dig),
        .step_o (step)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Display content as a pure function of steps taken since the last clear.
    function automatic logic [6:0] pattern(input int m, input int steps, input int sidx);
        case (m)
            0:       return (steps % 2 == 1) ? 7'h7F : 7'h00;
            1:       return 7'(1 << (steps % 6));
            2:       return (sidx == steps % N) ? 7'h40 : 7'h00;
            default: return (sidx == (steps / 6) % N) ? 7'(1 << (steps % 6)) : 7'h00;
        endcase
    endfunction

    int           m_mode  = 0;
    int           m_cnt   = 0;
    int           m_steps = 0;
    longint       m_cyc   = 0;
    logic [6:0]   exp_seg = '0;
    logic [N-1:0] exp_dig = N'(1);
    logic         exp_step = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = 0; m_cnt = 0; m_steps = 0; m_cyc = 0;
            exp_seg = '0; exp_dig = N'(1); exp_step = 1'b0;
        end else begin
            int sidx;
            int period;
            sidx    = int'((m_cyc / SD) % N);
            exp_dig = N'(1) << sidx;
            exp_seg = pattern(m_mode, m_steps, sidx);
            period  = PS >> speed;
            exp_step = 1'b0;
            if (int'(mode) != m_mode) begin
                m_mode = int'(mode); m_cnt = 0; m_steps = 0;
            end else if (!pause) begin
                if (m_cnt + 1 >= period) begin
                    m_cnt = 0; m_steps++; exp_step = 1'b1;
                end else begin
                    m_cnt++;
                end
            end
            m_cyc++;
        end
    end

    always @(negedge clk) begin
        check("seg", int'(seg), int'(exp_seg));
        check("dig", int'(dig), int'(exp_dig));
        check("step", int'(step), int'(exp_step));
    end

    task automatic wait_step(output longint t);
        int k;
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (step) break;
        end
        check("step_wait_bound", int'(k < 200), 1);
        t = cyc;
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    logic [6:0] spin_tab [7] = '{7'h02, 7'h04, 7'h08, 7'h10, 7'h20, 7'h01, 7'h02};

    initial begin
        longint t0, t1, t2, tp;
        int steps_seen, dig_moves, k;
        logic [N-1:0] prev_dig;

        mode = 2'd0; speed = 2'd0; pause = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_dig", int'(dig), 1);
        check("rst_seg", int'(seg), 0);
        check("rst_step", int'(step), 0);

        // FLASH at full period
        t0 = cyc;
        rst_n = 1'b1;
        wait_step(t1);
        check("first_step_latency", int'(t1 - t0), 16);
        @(negedge clk);
        check("flash_on", int'(seg), 'h7F);
        wait_step(t2);
        check("flash_period", int'(t2 - t1), 16);
        @(negedge clk);
        check("flash_off", int'(seg), 'h00);

        // Speed raised while the count is already past the new limit
        repeat (8) @(posedge clk);
        #1 speed = 2'd2;
        t0 = cyc;
        wait_step(t1);
        check("speed_immediate_step", int'(t1 - t0), 1);

        // SPIN at speed 2
        after_edge();
        mode = 2'd1;
        repeat (3) @(negedge clk);
        check("spin_start", int'(seg), 'h01);
        tp = 0;
        for (int i = 0; i < 7; i++) begin
            wait_step(t1);
            if (i > 0) check("spin_period", int'(t1 - tp), 4);
            tp = t1;
            @(negedge clk);
            check("spin_seq", int'(seg), int'(spin_tab[i]));
        end

        // Mode change mid-period restarts the count
        after_edge();
        mode = 2'd2;
        t0 = cyc;
        wait_step(t1);
        check("mode_change_restart", int'(t1 - t0), 5);

        // Pause in CHASE: timer frozen, scan keeps running
        after_edge();
        pause = 1'b1;
        steps_seen = 0; dig_moves = 0; prev_dig = dig;
        repeat (40) begin
            @(negedge clk);
            if (step) steps_seen++;
            if (dig != prev_dig) dig_moves++;
            prev_dig = dig;
        end
        check("pause_no_step", steps_seen, 0);
        check("pause_scan_runs", int'(dig_moves > 15), 1);
        after_edge();
        pause = 1'b0;
        t0 = cyc;
        wait_step(t1);
        check("resume_from_held", int'(t1 - t0), 3);

        // SNAKE at full period: after 6 steps the snake sits on digit 1, segment a
        after_edge();
        mode = 2'd3; speed = 2'd0;
        repeat (6) wait_step(t1);
        @(negedge clk);
        for (k = 0; k < 12; k++) begin
            @(negedge clk);
            if (dig == N'(2)) break;
        end
        check("snake_dig1_found", int'(k < 12), 1);
        check("snake_dig1_seg", int'(seg), 'h01);
        for (k = 0; k < 12; k++) begin
            @(negedge clk);
            if (dig == N'(1)) break;
        end
        check("snake_dig0_found", int'(k < 12), 1);
        check("snake_dig0_seg", int'(seg), 'h00);
        repeat (6) wait_step(t1);

        // Random traffic, model compared every cycle
        for (int i = 0; i < 3000; i++) begin
            after_edge();
            if ($urandom_range(63) == 0) mode = 2'($urandom_range(3));
            if ($urandom_range(31) == 0) speed = 2'($urandom_range(3));
            if ($urandom_range(15) == 0) pause = ~pause;
        end

        // Asynchronous reset between clock edges
        pause = 1'b0;
        mode = 2'd3;
        repeat (20) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_dig", int'(dig), 1);
        check("async_rst_seg", int'(seg), 0);
        check("async_rst_step", int'(step), 0);
        mode = 2'd0; speed = 2'd0;
        @(negedge clk);
        t0 = cyc;
        rst_n = 1'b1;
        wait_step(t1);
        check("post_rst_latency", int'(t1 - t0), 16);
        repeat (4) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/seg7_pattern_engine.md
SEG7_PATTERN_ENGINE -- requirements
Module: seg7_pattern_engine

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of multiplexed digits (legal 1..8).
REQ-002 SHALL have parameter PRESCALE, default 20_000_000, clocks per animation step at speed 0 (legal >= 16).
REQ-003 SHALL have parameter SCAN_DIV, default 50_000, clocks per digit scan slot (legal >= 1).
REQ-004 SHALL have port clk_i, input, 1, sole clock, rising edge.
REQ-005 SHALL have port rst_ni, input, 1, reset, asynchronous, active-low.
REQ-006 SHALL have port mode_i, input, 2, pattern select: 0 FLASH, 1 SPIN, 2 CHASE, 3 SNAKE.
REQ-007 SHALL have port speed_i, input, 2, step period = PRESCALE >> speed_i clocks.
REQ-008 SHALL have port pause_i, input, 1, freezes the animation while high.
REQ-009 SHALL have port seg_o, output, 7, active-high segments, bit0=a .. bit6=g, for the scanned digit.
REQ-010 SHALL have port dig_o, output, NUM_DIGITS, one-hot active-high digit enable.
REQ-011 SHALL have port step_o, output, 1, one-cycle pulse on each animation step.

Function
REQ-012 SHALL increment a step counter each cycle while pause_i=0; the counter holds its value while pause_i=1.
REQ-013 SHALL count the cycle with counter >= (PRESCALE>>speed_i)-1 as a step: step_o=1 in the next cycle, counter returns to 0.
REQ-014 SHALL treat a speed_i change that leaves counter >= the new limit as an immediate step under the REQ-013 rule; no counter value is ever skipped past silently.
REQ-015 SHALL register mode_i; a change from the registered value SHALL clear counter, phase, seg_idx and pos to 0 in that cycle with no step.
REQ-016 SHALL, in FLASH, toggle phase each step; every digit shows 7'h7F when phase=1 and 7'h00 when phase=0.
REQ-017 SHALL, in SPIN, advance seg_idx 0..5 each step and wrap 5->0; every digit shows the one-hot segment (1<<seg_idx).
REQ-018 SHALL, in CHASE, advance pos 0..NUM_DIGITS-1 each step and wrap to 0; only digit pos shows 7'h40 (g), others 7'h00.
REQ-019 SHALL, in SNAKE, advance seg_idx 0..5 each step; on 5->0, pos increments and wraps; only digit pos shows (1<<seg_idx).
REQ-020 SHALL run the scan counter every cycle regardless of pause_i and mode; every SCAN_DIV clocks the scanned digit advances and wraps NUM_DIGITS-1 -> 0.
REQ-021 SHALL register dig_o and seg_o; both reflect the scan index and pattern state of the previous cycle, one cycle of latency.
REQ-022 SHALL hold dig_o exactly one-hot at all times, including NUM_DIGITS=1 where it is constantly 1.
REQ-023 SHALL, on pause_i=1 coincident with a terminal-count cycle, suppress the step; no step_o pulse and no state advance.

Reset
REQ-024 SHALL, while rst_ni=0, hold step counter, scan counter, phase, seg_idx, pos = 0; seg_o=7'h00; dig_o=1 (digit 0); step_o=0; registered mode=0.
REQ-025 SHALL, on reset assertion mid-animation, clear all state immediately without waiting for a clock edge, with the first step occurring PRESCALE>>speed_i clocks after release.

Verification
REQ-026 SHALL cover: PRESCALE=16, speed_i=0, mode 0, after reset release -> step_o pulses every 16 clocks, seg_o alternates 7'h7F/7'h00 on all digits.
REQ-027 SHALL cover: mode 1, speed_i=2, 7 steps -> step period of 4 clocks, seg_o sequence 01,02,04,08,10,20,01.
REQ-028 SHALL cover: NUM_DIGITS=4, SCAN_DIV=2, mode 3, 12 steps -> pos walks 0,1 with seg_idx 0..5 each, and dig_o cycles 1,2,4,8 every 2 clocks.
REQ-029 SHALL cover: pause_i high for 40 clocks in mode 2 -> no step_o, pos frozen, dig_o keeps scanning; release -> stepping resumes from the held counter value.
REQ-030 SHALL cover: mode_i changed 1->2 mid-period -> counter, seg_idx and pos cleared to 0, and the next step arrives a full period later.
REQ-031 SHALL cover: rst_ni pulsed low between clock edges -> outputs go to reset values asynchronously, with dig_o=1 and seg_o=0.
